// File: rtl/imem_pkg.sv
// Shared constants and PC helpers for the pipelined instruction memory.
package imem_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Helpers work on a widened PC so any ADDR_W up to 64 compares without truncation.
  function automatic logic [63:0] word_idx(input logic [63:0] pc);
    return pc >> 2;
  endfunction

  function automatic logic pc_fault(input logic [63:0] pc, input logic [63:0] depth);
    return (pc[1:0] != 2'b00) || (word_idx(pc) >= depth);
  endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch, output and load-port signals between the IF stage and the instruction memory.
interface imem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_ready;
  logic              stall;
  logic              flush;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              fault;
  logic              load_en;
  logic [ADDR_W-3:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;
  logic              busy;

  modport master (
    output fetch_req, fetch_pc, stall, flush, load_en, load_addr, load_data,
    input  fetch_ready, instr_valid, instr, instr_pc, fault, load_err, busy
  );

  modport slave (
    input  fetch_req, fetch_pc, stall, flush, load_en, load_addr, load_data,
    output fetch_ready, instr_valid, instr, instr_pc, fault, load_err, busy
  );
endinterface

// File: rtl/imem_ram.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
module imem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IDX_W  = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_pipe.sv
// Registered instruction fetch port with post-reset clear, run-time load and PC fault flagging.
module imem_pipe import imem_pkg::*; #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input logic   clk,
  input logic   rst_n,
  imem_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              sel_ram_q, sel_ram_d;
  logic              load_err_q, load_err_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              run, accept, fetch_bad, load_oob;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign run       = (state_q == ST_RUN);
  assign fetch_bad = pc_fault(64'(bus.fetch_pc), 64'(DEPTH));
  assign load_oob  = 64'(bus.load_addr) >= 64'(DEPTH);

  assign bus.fetch_ready = run & ~bus.stall & ~bus.flush & ~bus.load_en;
  assign accept          = bus.fetch_req & bus.fetch_ready;
  assign ram_re          = accept & ~fetch_bad;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_idx_q;
    ram_wdata = NOP_WORD;
    if (!run) begin
      ram_we = 1'b1;
    end else if (bus.load_en && !load_oob) begin
      ram_we    = 1'b1;
      ram_waddr = bus.load_addr[IDX_W-1:0];
      ram_wdata = bus.load_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    sel_ram_d  = sel_ram_q;
    pc_d       = pc_q;
    load_err_d = 1'b0;
    if (!run) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
        state_d   = ST_RUN;
        clr_idx_d = '0;
      end
    end else begin
      load_err_d = bus.load_en & load_oob;
      if (bus.flush) begin
        valid_d   = 1'b0;
        fault_d   = 1'b0;
        sel_ram_d = 1'b0;
      end else if (bus.stall) begin
        valid_d = valid_q;
      end else if (accept) begin
        valid_d   = 1'b1;
        pc_d      = bus.fetch_pc;
        fault_d   = fetch_bad;
        sel_ram_d = ~fetch_bad;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      sel_ram_q  <= 1'b0;
      load_err_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      sel_ram_q  <= sel_ram_d;
      load_err_q <= load_err_d;
      pc_q       <= pc_d;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (bus.fetch_pc[IDX_W+1:2]),
    .rdata_o (ram_rdata)
  );

  // The RAM read register only moves on a good accept, so it holds across stall and idle.
  assign bus.instr       = sel_ram_q ? ram_rdata : NOP_WORD;
  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = pc_q;
  assign bus.fault       = fault_q;
  assign bus.load_err    = load_err_q;
  assign bus.busy        = ~run;
endmodule

// File: tb/tb_imem_pipe.sv
// Directed bench for imem_pipe with a cycle-level reference model and literal spot checks.
module tb_imem_pipe;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 128;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  imem_pipe #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as an array, outputs derived from the behavioural rules.
  bit          m_init = 1'b0;
  int          m_left;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_instr, m_pc;
  bit          m_valid, m_fault, m_lerr;

  function automatic bit exp_bad(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc / 4 >= DEPTH);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init  <= 1'b1;
      m_left  <= DEPTH;
      m_valid <= 1'b0;
      m_instr <= '0;
      m_pc    <= '0;
      m_fault <= 1'b0;
      m_lerr  <= 1'b0;
      foreach (m_mem[i]) m_mem[i] <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_lerr <= 1'b0;
    end else begin
      m_lerr <= 1'b0;
      if (bus.load_en) begin
        if (bus.load_addr < DEPTH) m_mem[bus.load_addr] <= bus.load_data;
        else m_lerr <= 1'b1;
      end
      if (bus.flush) begin
        m_valid <= 1'b0;
        m_instr <= '0;
        m_fault <= 1'b0;
      end else if (bus.stall) begin
        m_valid <= m_valid;
      end else if (bus.fetch_req && !bus.load_en) begin
        m_valid <= 1'b1;
        m_pc    <= bus.fetch_pc;
        if (exp_bad(bus.fetch_pc)) begin
          m_instr <= '0;
          m_fault <= 1'b1;
        end else begin
          m_instr <= m_mem[bus.fetch_pc / 4];
          m_fault <= 1'b0;
        end
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp busy", 32'(bus.busy), 32'(m_left > 0));
      chk("cmp fetch_ready", 32'(bus.fetch_ready),
          32'(m_left == 0 && !bus.stall && !bus.flush && !bus.load_en));
      chk("cmp instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      chk("cmp load_err", 32'(bus.load_err), 32'(m_lerr));
      if (m_valid) begin
        chk("cmp instr", bus.instr, m_instr);
        chk("cmp instr_pc", bus.instr_pc, m_pc);
        chk("cmp fault", 32'(bus.fault), 32'(m_fault));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = pc;
    step();
    bus.fetch_req = 1'b0;
  endtask

  task automatic load(input int unsigned addr, input logic [31:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = 30'(addr);
    bus.load_data = data;
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int cnt = 0;
    bit rdy = 1'b0;
    while (bus.busy && cnt < 400) begin
      cnt++;
      if (bus.fetch_ready) rdy = 1'b1;
      step();
    end
    chk(name, 32'(cnt), 32'd128);
    chk({name, " ready"}, 32'(rdy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.fetch_req = 1'b0;
    bus.fetch_pc  = '0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    repeat (3) step();
    chk("reset valid", 32'(bus.instr_valid), 32'd0);
    chk("reset instr", bus.instr, 32'h0);
    chk("reset pc", bus.instr_pc, 32'h0);
    chk("reset lerr", 32'(bus.load_err), 32'd0);

    // Request held through the clear: must not be taken until RUN.
    rst_n         = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0;
    wait_clear("clear len");
    step();
    bus.fetch_req = 1'b0;
    chk("first valid", 32'(bus.instr_valid), 32'd1);
    chk("first instr", bus.instr, 32'h0);
    chk("first fault", 32'(bus.fault), 32'd0);

    load(0, 32'h2008_0020);
    load(1, 32'h2009_0037);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0;
    step();
    chk("b2b instr0", bus.instr, 32'h2008_0020);
    chk("b2b pc0", bus.instr_pc, 32'h0);
    bus.fetch_pc = 32'h4;
    step();
    chk("b2b instr1", bus.instr, 32'h2009_0037);
    chk("b2b pc1", bus.instr_pc, 32'h4);
    bus.fetch_req = 1'b0;
    step();
    chk("idle valid", 32'(bus.instr_valid), 32'd0);

    fetch(32'h6);
    chk("misalign fault", 32'(bus.fault), 32'd1);
    chk("misalign instr", bus.instr, 32'h0);
    fetch(32'h200);
    chk("oob fault", 32'(bus.fault), 32'd1);
    chk("oob no alias", bus.instr, 32'h0);
    load(200, 32'hDEAD_BEEF);
    chk("load_err pulse", 32'(bus.load_err), 32'd1);
    step();
    chk("load_err drop", 32'(bus.load_err), 32'd0);
    fetch(32'h120);
    chk("no alias write", bus.instr, 32'h0);

    fetch(32'h4);
    bus.stall     = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall ready", 32'(bus.fetch_ready), 32'd0);
      step();
      chk("stall instr", bus.instr, 32'h2009_0037);
      chk("stall pc", bus.instr_pc, 32'h4);
    end
    bus.flush = 1'b1;
    step();
    chk("flush valid", 32'(bus.instr_valid), 32'd0);
    chk("flush instr", bus.instr, 32'h0);
    chk("flush pc", bus.instr_pc, 32'h4);
    bus.flush     = 1'b0;
    bus.stall     = 1'b0;
    bus.fetch_req = 1'b0;

    bus.load_en   = 1'b1;
    bus.load_addr = 30'd5;
    bus.load_data = 32'h1234_5678;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h14;
    #1;
    chk("load blocks ready", 32'(bus.fetch_ready), 32'd0);
    step();
    chk("load no accept", 32'(bus.instr_valid), 32'd0);
    bus.load_en = 1'b0;
    step();
    bus.fetch_req = 1'b0;
    chk("wr then rd", bus.instr, 32'h1234_5678);
    chk("wr then rd pc", bus.instr_pc, 32'h14);

    bus.stall = 1'b1;
    load(6, 32'hCAFE_F00D);
    bus.stall = 1'b0;
    fetch(32'h18);
    chk("load in stall", bus.instr, 32'hCAFE_F00D);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (50) step();
    chk("mid clear busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_clear("restart len");
    fetch(32'h0);
    chk("cleared word", bus.instr, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
